// File: rtl/pattern_serializer.sv
// pattern_serializer: frames a parallel word as sync pattern, data MSB-first and even parity on one serial line.
module pattern_serializer #(
  parameter int WIDTH = 8,
  parameter int SYNC_LEN = 4,
  parameter logic [SYNC_LEN-1:0] SYNC = 4'b1101
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             valid,
  output logic             ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);
  localparam int FL = SYNC_LEN + WIDTH;
  localparam int MX = SYNC_LEN > WIDTH ? SYNC_LEN : WIDTH;
  localparam int CW = MX > 1 ? $clog2(MX) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_PAR} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [FL-1:0] fr, fr_n;
  logic par, par_n, sout_n, busy_n, done_n;
  assign ready = state == S_IDLE || state == S_PAR;
  // sync and data share one shift register; the counter only marks the phase boundaries
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    fr_n = fr;
    par_n = par;
    sout_n = 1'b0;
    busy_n = 1'b1;
    done_n = 1'b0;
    if (ready && valid) begin
      state_n = S_SYNC;
      cnt_n = CW'(SYNC_LEN - 1);
      fr_n = {SYNC, din} << 1;
      par_n = ^din;
      sout_n = SYNC[SYNC_LEN-1];
    end else if (ready) begin
      state_n = S_IDLE;
      busy_n = 1'b0;
    end else if (state == S_DATA && cnt == '0) begin
      state_n = S_PAR;
      cnt_n = '0;
      sout_n = par;
      done_n = 1'b1;
    end else begin
      sout_n = fr[FL-1];
      fr_n = fr << 1;
      cnt_n = cnt == '0 ? CW'(WIDTH - 1) : cnt - CW'(1);
      state_n = cnt == '0 ? S_DATA : state;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
      fr <= '0;
      par <= 1'b0;
      sout <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      fr <= fr_n;
      par <= par_n;
      sout <= sout_n;
      busy <= busy_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_pattern_serializer.sv
// tb_pattern_serializer: scoreboard of expected serial bits plus table-driven captured frames.
module tb_pattern_serializer;
  logic clk = 1'b0, reset = 1'b1, valid = 1'b0;
  logic [7:0] din = '0;
  logic ready, sout, busy, done;
  int checks = 0, errors = 0;
  bit mon = 1'b0;
  typedef struct { bit b; bit last; } exp_t;
  exp_t q[$];
  typedef struct { logic [7:0] d; logic [12:0] frame; } vec_t;
  vec_t vecs[7];

  pattern_serializer dut (.clk(clk), .reset(reset), .din(din), .valid(valid),
    .ready(ready), .sout(sout), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", n, $time, a, e);
    end
  endtask

  // model: accept only when no frame bits are outstanding
  always @(posedge clk) begin
    if (reset) q.delete();
    else if (valid && q.size() == 0) begin
      logic [12:0] f;
      f = {4'b1101, din, ^din};
      for (int i = 12; i >= 0; i--) q.push_back('{b: f[i], last: i == 0});
    end
  end

  always @(negedge clk) begin
    if (mon) begin
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("sout", sout, e.b);
        chk("done", done, e.last);
        chk("busy", busy, 1'b1);
        chk("ready", ready, e.last);
      end else begin
        chk("idle_sout", sout, 1'b0);
        chk("idle_done", done, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_ready", ready, 1'b1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_capture(input logic [7:0] d, input logic [12:0] frame);
    logic [12:0] cap;
    din = d;
    valid = 1'b1;
    step(1);
    valid = 1'b0;
    cap = '0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      cap = {cap[11:0], sout};
    end
    checks++;
    if (cap !== frame) begin
      errors++;
      $display("FAIL frame_%h: got %b expected %b", d, cap, frame);
    end
    step(2);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 13'b1101_10100101_0};
    vecs[1] = '{8'h01, 13'b1101_00000001_1};
    vecs[2] = '{8'h00, 13'b1101_00000000_0};
    vecs[3] = '{8'h3C, 13'b1101_00111100_0};
    vecs[4] = '{8'h5A, 13'b1101_01011010_0};
    vecs[5] = '{8'h80, 13'b1101_10000000_1};
    vecs[6] = '{8'h7F, 13'b1101_01111111_1};
    step(3);
    reset = 1'b0;
    step(1);
    mon = 1'b1;
    step(20);
    for (int i = 0; i < 7; i++) send_capture(vecs[i].d, vecs[i].frame);
    // back-to-back: valid held across the parity cycle
    din = 8'hA5;
    valid = 1'b1;
    step(1);
    din = 8'h01;
    step(13);
    valid = 1'b0;
    step(16);
    // valid pulsed mid-frame must be ignored
    din = 8'h00;
    valid = 1'b1;
    step(1);
    valid = 1'b0;
    step(6);
    din = 8'hFF;
    valid = 1'b1;
    step(1);
    valid = 1'b0;
    din = 8'h00;
    step(10);
    // reset during DATA aborts the frame
    din = 8'h3C;
    valid = 1'b1;
    step(1);
    valid = 1'b0;
    step(6);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(3);
    send_capture(8'h3C, 13'b1101_00111100_0);
    // reset wins over a simultaneous handshake
    din = 8'hA5;
    valid = 1'b1;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    valid = 1'b0;
    step(3);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d expected 0 pending bits", q.size());
    end
    mon = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pattern_serializer.md
# pattern_serializer

Frame transmitter for the serial pattern path: accepts a parallel word over a valid/ready handshake and shifts it out on a single-bit serial line. Each frame is a fixed sync pattern, the data word MSB-first, then an even-parity bit. It drives the serial input of the Mealy pattern detector, so the sync pattern it emits is what the detector recognises. A `done` strobe marks each frame's last bit, so benches and downstream logic can align on frame boundaries.

## Interface
- `WIDTH`, 8 — data word width in bits (≥1).
- `SYNC_LEN`, 4 — sync pattern length in bits (≥1).
- `SYNC`, 4'b1101 — sync pattern, `SYNC_LEN` bits, sent MSB first.

Ports:
- `clk`  in  1  — single clock; all logic on the rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `din`  in  `WIDTH`  — word to transmit; sampled only on a handshake.
- `valid`  in  1  — `din` is valid.
- `ready`  out  1  — block can accept a word this cycle (combinational from state).
- `sout`  out  1  — serial output, registered.
- `busy`  out  1  — frame in progress, registered.
- `done`  out  1  — high for exactly the cycle in which the parity bit is on `sout`, registered.

## Operation
- Reset values: state IDLE, `sout`=0, `busy`=0, `done`=0, `ready`=1, shift register and counter cleared.
- States:
  - IDLE: `sout`=0, `ready`=1.
  - SYNC: emits `SYNC_LEN` bits.
  - DATA: emits `WIDTH` bits.
  - PAR: emits one parity bit, `ready`=1.
- Handshake: a transfer occurs on a rising edge with `valid`&&`ready`=1. `din` is captured into the shift register and the parity register (parity = XOR of all `din` bits, even parity). State goes to SYNC with the bit counter at `SYNC_LEN`-1.
- `valid` with `ready`=0 (SYNC/DATA) is ignored. `din` is not sampled, and the word is not queued.
- Transitions:
  - IDLE→SYNC on handshake.
  - SYNC→DATA after the last sync bit.
  - DATA→PAR after the last data bit.
  - PAR→SYNC on handshake (back-to-back, no gap).
  - PAR→IDLE otherwise.
- Bit order: sync `SYNC[SYNC_LEN-1]` down to `SYNC[0]`, then `din[WIDTH-1]` down to `din[0]`, then parity.
- Counter width: `$clog2(max(SYNC_LEN,WIDTH))`, with a minimum of 1 bit. It counts down and reloads on each state change.
- `busy`=1 whenever `sout` carries a frame bit (SYNC, DATA, PAR), otherwise 0.
- Reset asserted mid-frame: the frame is aborted. On the next edge, all outputs take their reset values. No partial parity or `done` is emitted.
- Reset has priority over a simultaneous handshake; the word is dropped.

## Timing
- Handshake at edge k: the first sync bit is on `sout` in cycle k+1, i.e. after edge k.
- Frame length: `SYNC_LEN`+`WIDTH`+1 cycles (13 with defaults).
- With defaults:
  - sync in cycles k+1..k+4.
  - data in k+5..k+12.
  - parity plus `done`=1 in k+13.
- Back-to-back: a handshake at the edge ending the PAR cycle starts the next sync bit in the immediately following cycle. Throughput is one frame per `SYNC_LEN`+`WIDTH`+1 cycles, with no idle bit.
- Without a handshake at the PAR edge, the next cycle has `sout`=0, `busy`=0, `done`=0.
- `ready` is asserted in IDLE and PAR, and deasserted in SYNC and DATA.

## Test plan
- Reset then idle, `valid`=0 for 20 cycles -> `sout`=0, `busy`=0, `done`=0, `ready`=1 throughout.
- Single frame, `din`=8'hA5 -> `sout` = 1,1,0,1, 1,0,1,0,0,1,0,1, 0 in cycles k+1..k+13. `done`=1 only at k+13. `busy`=1 over k+1..k+13. Back to IDLE at k+14.
- Back-to-back `din`=8'hA5 then 8'h01 (`valid` held high) -> 26 contiguous frame bits. The second frame's parity is 1. `done` pulses at k+13 and k+26. `ready` is low except in IDLE and PAR cycles.
- `valid` pulsed with `din`=8'hFF during the DATA phase of an 8'h00 frame -> the frame is unchanged (data all 0, parity 0), and 8'hFF is never transmitted.
- `reset` asserted at k+7 of an 8'h3C frame -> `sout`=0, `busy`=0 from k+8, with no `done`. A new 8'h3C handshake afterwards yields a full correct frame: 1101 00111100, parity 0.
- Loopback into the pattern detector: frames 8'h00, 8'h5A -> detector `y` asserts on each sync pattern. The serializer bit stream matches the golden vector file exactly.
